// File: rtl/barret_1543_rr_sched.sv
// barret_1543_rr_sched
//
// Round-robin scheduler in front of a shared 3-stage Barrett reduction
// pipeline (modulus 1543, 21-bit operands). At most one requester is granted
// per cycle. Its operand is reduced to 0..1542 and returned together with the
// requester index on a single backpressured output channel.
//
// Handshake rule (both channels): a beat moves on a rising edge where
// valid and ready are both high. req_ready is a combinational function of
// req_valid, so a requester must never make req_valid depend on req_ready.
// Once out_valid is raised, out_data/out_id stay frozen until out_ready.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  [NREQ]      requester i holds an operand
//   req_ready  [NREQ]      one-hot grant (zero while stalled or in reset)
//   req_data   [NREQ*21]   operand i in bits [21*i+20 : 21*i]
//   out_valid              result present
//   out_ready              consumer accepts the result
//   out_data   [11]        operand mod 1543
//   out_id     [ID_W]      index of the issuing requester
//   busy                   any pipeline stage holds a valid entry

module barret_1543_rr_sched #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*21-1:0] req_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [10:0]        out_data,
    output logic [ID_W-1:0]    out_id,
    output logic               busy
);

    localparam logic [20:0] MODULUS = 21'd1543;
    localparam logic [21:0] MU      = 22'd2718;  // floor(2^22 / 1543)

    // Round-robin pointer: the requester searched first this cycle.
    logic [ID_W-1:0] ptr;

    // Stage 1 registers
    logic            v1;
    logic [20:0]     a1;
    logic [ID_W-1:0] id1;

    // Stage 2 registers
    logic            v2;
    logic [20:0]     a2;
    logic [10:0]     t2;
    logic [ID_W-1:0] id2;

    // Combinational signals
    logic            stall;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic            transfer;
    logic [20:0]     a_sel;
    logic [9:0]      qv;
    logic [21:0]     qh;
    logic [10:0]     t_s2;
    logic [20:0]     m_s3;
    logic [12:0]     r0;
    logic [12:0]     r1;
    logic [10:0]     r2;

    assign stall = out_valid & ~out_ready;

    // Search req_valid from ptr upward, wrapping at NREQ-1; first hit wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Reset is folded in so req_ready is zero in every cycle rst is sampled.
    assign transfer = grant_found & ~stall & ~rst;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign a_sel = req_data[int'(grant_id)*21 +: 21];

    // Stage 2: quotient estimate t = floor(floor(a / 2^11) * mu / 2^11).
    // The estimate undershoots the true quotient by at most 2.
    assign qv   = a1[20:11];
    assign qh   = 22'(qv) * MU;
    assign t_s2 = 11'(qh >> 11);

    // Stage 3: remainder estimate then up to two corrective subtractions.
    // t <= 1357 keeps t*1543 within 21 bits, and r stays below 3*1543.
    assign m_s3 = 21'(t2) * MODULUS;
    assign r0   = 13'(a2 - m_s3);
    assign r1   = (r0 >= 13'(MODULUS)) ? (r0 - 13'(MODULUS)) : r0;
    assign r2   = 11'((r1 >= 13'(MODULUS)) ? (r1 - 13'(MODULUS)) : r1);

    // Whole pipeline, pointer and outputs freeze together on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            v1        <= 1'b0;
            a1        <= '0;
            id1       <= '0;
            v2        <= 1'b0;
            a2        <= '0;
            t2        <= '0;
            id2       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (!stall) begin
            v1        <= transfer;
            a1        <= a_sel;
            id1       <= grant_id;
            v2        <= v1;
            a2        <= a1;
            t2        <= t_s2;
            id2       <= id1;
            out_valid <= v2;
            out_data  <= r2;
            out_id    <= id2;
            if (transfer) begin
                ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    assign busy = v1 | v2 | out_valid;

endmodule

// File: tb/tb_barret_1543_rr_sched.sv
module tb_barret_1543_rr_sched;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*21-1:0] req_data;
    logic               out_valid;
    logic               out_ready;
    logic [10:0]        out_data;
    logic [ID_W-1:0]    out_id;
    logic               busy;

    always #5 clk = ~clk;

    barret_1543_rr_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rand_ready = 1'b0;

    // Per-requester operand queues (the drivers)
    logic [20:0] src_q [NREQ][$];

    // Reference model: pointer plus three in-flight slots (slot 2 = output)
    int m_ptr = 0;
    bit m_v [3];
    int m_d [3];
    int m_id[3];

    // Observation logs
    int grant_log[$];
    int acc_cyc_log[$];
    int out_d_log[$];
    int out_id_log[$];
    int out_cyc_log[$];

    function automatic void clear_logs();
        grant_log.delete();
        acc_cyc_log.delete();
        out_d_log.delete();
        out_id_log.delete();
        out_cyc_log.delete();
    endfunction

    function automatic bit all_idle();
        bit idle;
        idle = !(m_v[0] || m_v[1] || m_v[2]);
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() != 0) idle = 1'b0;
        end
        return idle;
    endfunction

    // One clock cycle: drive from queues, check against model, step model.
    // Called and returns at a falling edge.
    task automatic cycle();
        int g;
        bit stall;
        bit xfer;
        logic [NREQ-1:0] exp_rdy;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (src_q[i].size() != 0);
            req_data[21*i +: 21] = (src_q[i].size() != 0) ? src_q[i][0] : 21'd0;
        end
        #1;
        stall = m_v[2] && !out_ready;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        xfer = (g >= 0) && !stall && !rst;
        exp_rdy = '0;
        if (xfer) exp_rdy[g] = 1'b1;

        n_vec++;
        if (req_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL req_ready cyc %0d: got %b want %b", cyc, req_ready, exp_rdy);
        end
        n_vec++;
        if (out_valid !== m_v[2]) begin
            n_err++;
            $display("FAIL out_valid cyc %0d: got %b want %b", cyc, out_valid, m_v[2]);
        end
        n_vec++;
        if (busy !== (m_v[0] | m_v[1] | m_v[2])) begin
            n_err++;
            $display("FAIL busy cyc %0d: got %b want %b", cyc, busy, m_v[0] | m_v[1] | m_v[2]);
        end
        if (m_v[2]) begin
            n_vec++;
            if (out_data !== 11'(m_d[2])) begin
                n_err++;
                $display("FAIL out_data cyc %0d: got %0d want %0d", cyc, out_data, m_d[2]);
            end
            n_vec++;
            if (out_id !== ID_W'(m_id[2])) begin
                n_err++;
                $display("FAIL out_id cyc %0d: got %0d want %0d", cyc, out_id, m_id[2]);
            end
        end
        if (out_valid === 1'b1 && out_ready && !rst) begin
            out_d_log.push_back(int'(out_data));
            out_id_log.push_back(int'(out_id));
            out_cyc_log.push_back(cyc);
        end

        @(posedge clk);
        if (rst) begin
            m_v[0] = 1'b0;
            m_v[1] = 1'b0;
            m_v[2] = 1'b0;
            m_ptr  = 0;
        end else if (!stall) begin
            m_v[2] = m_v[1]; m_d[2] = m_d[1]; m_id[2] = m_id[1];
            m_v[1] = m_v[0]; m_d[1] = m_d[0]; m_id[1] = m_id[0];
            m_v[0] = xfer;
            if (xfer) begin
                m_d[0]  = int'(src_q[g][0]) % 1543;
                m_id[0] = g;
                void'(src_q[g].pop_front());
                m_ptr = (g + 1) % NREQ;
                grant_log.push_back(g);
                acc_cyc_log.push_back(cyc);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (all_idle()) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        if (!done && all_idle()) done = 1'b1;
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL drain_timeout: got busy after %0d cycles want idle", budget);
            for (int i = 0; i < NREQ; i++) src_q[i].delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) src_q[i].push_back(21'(100 + i));
        @(posedge clk);
        @(negedge clk);
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (out_data !== 11'd0 || out_id !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got data %0d id %0d want 0 0", out_data, out_id);
            end
            cycle();
        end
        rst = 1'b0;
        cycle();
        n_vec++;
        if (grant_log.size() != 1 || grant_log[0] != 0) begin
            n_err++;
            $display("FAIL reset_first_grant: got %0d grants (first %0d) want requester 0",
                     grant_log.size(), (grant_log.size() != 0) ? grant_log[0] : -1);
        end
        drain(100);
    endtask

    task automatic test_single();
        int exp_d[5] = '{0, 1542, 0, 1542, 214};
        out_ready = 1'b1;
        clear_logs();
        src_q[2].push_back(21'd0);
        src_q[2].push_back(21'd1542);
        src_q[2].push_back(21'd1543);
        src_q[2].push_back(21'd3085);
        src_q[2].push_back(21'd2097151);
        drain(100);
        n_vec++;
        if (out_d_log.size() != 5 || acc_cyc_log.size() != 5) begin
            n_err++;
            $display("FAIL single_count: got %0d outputs want 5", out_d_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_vec++;
                if (out_d_log[k] != exp_d[k] || out_id_log[k] != 2 ||
                    out_cyc_log[k] != acc_cyc_log[0] + 3 + k) begin
                    n_err++;
                    $display("FAIL single_out%0d: got data %0d id %0d cyc %0d want %0d 2 %0d",
                             k, out_d_log[k], out_id_log[k], out_cyc_log[k],
                             exp_d[k], acc_cyc_log[0] + 3 + k);
                end
            end
        end
    endtask

    task automatic test_all_four();
        out_ready = 1'b1;
        do_reset();
        clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 3; k++) src_q[i].push_back(21'($urandom_range(0, 2097151)));
        end
        drain(100);
        n_vec++;
        if (grant_log.size() != 12 || out_id_log.size() != 12) begin
            n_err++;
            $display("FAIL rr_count: got %0d grants %0d outputs want 12", grant_log.size(), out_id_log.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                n_vec++;
                if (grant_log[k] != k % 4 || out_id_log[k] != k % 4 ||
                    acc_cyc_log[k] != acc_cyc_log[0] + k) begin
                    n_err++;
                    $display("FAIL rr_order%0d: got grant %0d id %0d cyc %0d want %0d %0d %0d",
                             k, grant_log[k], out_id_log[k], acc_cyc_log[k], k % 4, k % 4, acc_cyc_log[0] + k);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [10:0]     sd;
        logic [ID_W-1:0] sid;
        int last_g;
        int n_gr;
        out_ready = 1'b1;
        do_reset();
        clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 6; k++) src_q[i].push_back(21'($urandom_range(0, 2097151)));
        end
        repeat (6) cycle();
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_prestall_valid: got %b want 1", out_valid);
        end
        sd = out_data;
        sid = out_id;
        last_g = grant_log[$];
        n_gr = grant_log.size();
        out_ready = 1'b0;
        repeat (5) begin
            cycle();
            n_vec++;
            if (out_data !== sd || out_id !== sid || grant_log.size() != n_gr) begin
                n_err++;
                $display("FAIL bp_frozen: got data %0d id %0d grants %0d want %0d %0d %0d",
                         out_data, out_id, grant_log.size(), sd, sid, n_gr);
            end
        end
        out_ready = 1'b1;
        cycle();
        n_vec++;
        if (grant_log.size() != n_gr + 1 || grant_log[$] != (last_g + 1) % NREQ) begin
            n_err++;
            $display("FAIL bp_resume_grant: got %0d want %0d", grant_log[$], (last_g + 1) % NREQ);
        end
        drain(200);
        n_vec++;
        if (out_d_log.size() != 24) begin
            n_err++;
            $display("FAIL bp_total: got %0d outputs want 24", out_d_log.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        do_reset();
        clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < 4; k++) src_q[i].push_back(21'($urandom_range(0, 2097151)));
        end
        repeat (3) cycle();
        n_vec++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_full: got valid %b busy %b want 1 1", out_valid, busy);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_after_rst: got valid %b busy %b want 0 0", out_valid, busy);
        end
        clear_logs();
        cycle();
        n_vec++;
        if (grant_log.size() != 1 || grant_log[0] != 0) begin
            n_err++;
            $display("FAIL mid_ptr: got grant %0d want 0", (grant_log.size() != 0) ? grant_log[0] : -1);
        end
        drain(200);
    endtask

    task automatic test_random();
        int edges[12] = '{0, 1, 1542, 1543, 1544, 3085, 3086, 2047, 2048,
                          2096936, 2096937, 2097151};
        int cnt[NREQ];
        int total;
        out_ready = 1'b1;
        do_reset();
        clear_logs();
        total = 0;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        for (int k = 0; k < 2500; k++) begin
            int r;
            logic [20:0] a;
            r = $urandom_range(0, NREQ - 1);
            a = (k < 12) ? 21'(edges[k]) : 21'($urandom_range(0, 2097151));
            src_q[r].push_back(a);
            cnt[r]++;
            total++;
        end
        rand_ready = 1'b1;
        drain(20000);
        rand_ready = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (out_d_log.size() != total) begin
            n_err++;
            $display("FAIL rand_total: got %0d outputs want %0d", out_d_log.size(), total);
        end
        for (int i = 0; i < NREQ; i++) begin
            int seen;
            seen = 0;
            foreach (out_id_log[j]) if (out_id_log[j] == i) seen++;
            n_vec++;
            if (seen != cnt[i]) begin
                n_err++;
                $display("FAIL rand_per_id%0d: got %0d want %0d", i, seen, cnt[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        req_valid = '0;
        req_data = '0;
        for (int s = 0; s < 3; s++) begin
            m_v[s] = 1'b0;
            m_d[s] = 0;
            m_id[s] = 0;
        end
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
